set_dispatch: RTL
=================

Name: set_dispatch

Overview:
- Front-end command dispatcher for the circle-set counting engine (ports en/central/radius/mode/busy/valid/candidate).
- Buffers host queries in a small FIFO and launches them one at a time using the engine's en/busy handshake.
- Captures the engine's one-cycle valid/candidate pulse into a held result register with a sequence tag.
- A watchdog flags an engine that never returns a result.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, >=2)
- TAG_W, 4, width of the per-command sequence tag
- TIMEOUT, 511, max cycles from launch to engine valid before error

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  host offers a command
- cmd_ready  out  1  FIFO not full
- cmd_central  in  24  {x1,y1,x2,y2,x3,y3}, 4 bits each, x1 in [23:20]
- cmd_radius  in  12  {r1,r2,r3}, r1 in [11:8]
- cmd_mode  in  2  engine mode, passed through unchanged
- set_en  out  1  launch pulse to engine
- set_central  out  24  head command centres, held stable from launch to result
- set_radius  out  12  head command radii, held stable from launch to result
- set_mode  out  2  head command mode, held stable from launch to result
- set_busy  in  1  engine busy
- set_valid  in  1  engine result strobe, one cycle
- set_candidate  in  8  engine count
- res_valid  out  1  result register full
- res_ready  in  1  consumer accepts result
- res_count  out  8  captured candidate
- res_tag  out  TAG_W  tag of the command that produced the result
- res_err  out  1  result produced by timeout, not by the engine

Behaviour:
- Reset (async, rst=1): FSM to IDLE; FIFO empty; tag counter 0; watchdog 0. Outputs: cmd_ready=1, set_en=0, set_central/radius/mode=0, res_valid=0, res_count=0, res_tag=0, res_err=0.
- Push: a command is accepted when cmd_valid && cmd_ready. It is written with tag = tag counter, and the counter increments, wrapping modulo 2^TAG_W.
- Push and pop in the same cycle are legal when the FIFO is full. cmd_ready reflects the registered full flag only.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, RUN, DRAIN.
- IDLE -> LAUNCH when the FIFO is non-empty, set_busy=0 and res_valid=0 (or res_valid && res_ready this cycle). set_* load from the FIFO head.
- LAUNCH: set_en=1 for exactly one cycle. Go to WAIT_BUSY.
- WAIT_BUSY: set_en=0; wait for set_busy=1, then go to RUN.
- RUN: on set_valid=1, capture set_candidate into res_count and the head tag into res_tag, set res_err=0 and res_valid=1, pop the FIFO head, then go to DRAIN.
- DRAIN: wait for set_busy=0 (the engine drops busy one cycle after valid), then go to IDLE.
- Minimum latency: a command pushed into an empty FIFO at cycle N gives set_en=1 at cycle N+2. res_valid rises the cycle after set_valid is sampled.
- Watchdog: counts from LAUNCH while in WAIT_BUSY or RUN. If it reaches TIMEOUT:
  - res_valid=1, res_err=1, res_count=0, res_tag=head tag;
  - pop the head, go to DRAIN;
  - DRAIN also exits after TIMEOUT further cycles, so a hung busy still returns to IDLE.
- set_valid outside RUN is ignored.
- set_* are held constant from LAUNCH until the pop. The engine latches them on en, but they are held anyway for robustness.
- Result register: res_valid clears on res_ready. The next launch is held off while the register is full, so no engine result can be lost.
- The command FIFO keeps accepting commands during engine runs.
- rst asserted mid-run clears everything immediately. Queued commands are discarded. The engine shares rst, so it also aborts.

Decomposition:
- Shared package: state enum {IDLE,LAUNCH,WAIT_BUSY,RUN,DRAIN}.
- Shared package: command struct {central[23:0], radius[11:0], mode[1:0], tag}.
- Shared package: field-slice constants (X1_HI=23, ...).
- One sub-module: set_cmd_fifo (synchronous FIFO, DEPTH x struct, full/empty, async reset).
- The FSM, watchdog and result register stay in set_dispatch.

Test Plan:
- Single command: push central=24'h44_00_00, radius=12'h300, mode=0 into the bench engine model (candidate=8'd29, 259-cycle run) -> set_en pulses once 2 cycles after push; res_valid=1, res_count=29, res_tag=0, res_err=0.
- Burst of 5 with DEPTH=4 and the engine busy -> cmd_ready=0 after the 4th queued push. All 5 results return in order with tags 0..4, and each set_en waits for set_busy to fall.
- Back-pressure: res_ready=0 after the first result -> no second set_en until res_ready=1; res_count is stable the whole time.
- Tag wrap: 17 commands with TAG_W=4 -> the 17th result has res_tag=0.
- Timeout: the engine model never raises valid -> at TIMEOUT (511) cycles after launch: res_valid=1, res_err=1, res_count=0. The FSM returns to IDLE, and the next command launches normally.
- Async reset in RUN with 3 commands queued -> all outputs hit reset values without a clock edge. After release, no set_en occurs until a new push.

Source files
------------

// File: rtl/set_dispatch_pkg.sv
// Shared types for the circle-set command dispatcher: FSM states, the queued
// command record and the bit positions of the packed centre/radius fields.
package set_dispatch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      RUN,
      DRAIN
   } state_t;

   // Tag storage is sized for the widest supported tag; narrower tags are zero-extended.
   localparam int CMD_TAG_W = 8;

   localparam int X1_HI = 23;
   localparam int X1_LO = 20;
   localparam int Y1_HI = 19;
   localparam int Y1_LO = 16;
   localparam int X2_HI = 15;
   localparam int X2_LO = 12;
   localparam int Y2_HI = 11;
   localparam int Y2_LO = 8;
   localparam int X3_HI = 7;
   localparam int X3_LO = 4;
   localparam int Y3_HI = 3;
   localparam int Y3_LO = 0;
   localparam int R1_HI = 11;
   localparam int R1_LO = 8;
   localparam int R2_HI = 7;
   localparam int R2_LO = 4;
   localparam int R3_HI = 3;
   localparam int R3_LO = 0;

   typedef struct packed {
      logic [23:0]          central;
      logic [11:0]          radius;
      logic [1:0]           mode;
      logic [CMD_TAG_W-1:0] tag;
   } cmd_t;

endpackage

// File: rtl/set_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible combinationally on rd_data.
// full/empty are registered so the host-facing ready has no comb path.
module set_cmd_fifo
   import set_dispatch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  cmd_t wr_data,
   output cmd_t rd_data,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   cmd_t           mem [DEPTH];
   logic [AW-1:0]  wr_ptr_reg;
   logic [AW-1:0]  rd_ptr_reg;
   logic [AW:0]    count_reg;
   logic [AW:0]    count_next;
   logic           full_reg;
   logic           empty_reg;
   logic           do_push;
   logic           do_pop;

   // A push into a full FIFO is allowed when the head pops in the same cycle.
   assign do_push = push && (!full_reg || pop);
   assign do_pop  = pop && !empty_reg;

   always_comb begin
      count_next = count_reg;
      if (do_push && !do_pop) begin
         count_next = count_reg + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
         count_next = count_reg - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_next;
         full_reg  <= (count_next == (AW+1)'(DEPTH));
         empty_reg <= (count_next == '0);
      end
   end

   assign rd_data = mem[rd_ptr_reg];
   assign full    = full_reg;
   assign empty   = empty_reg;

endmodule

// File: rtl/set_dispatch.sv
// Dispatcher in front of the circle-set engine: queues host commands, launches
// them with en/busy, holds each result with its tag, and times out a hung engine.
module set_dispatch
   import set_dispatch_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 511
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [23:0]      cmd_central,
   input  logic [11:0]      cmd_radius,
   input  logic [1:0]       cmd_mode,
   output logic             set_en,
   output logic [23:0]      set_central,
   output logic [11:0]      set_radius,
   output logic [1:0]       set_mode,
   input  logic             set_busy,
   input  logic             set_valid,
   input  logic [7:0]       set_candidate,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [7:0]       res_count,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_err
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   state_t           state_reg, state_next;
   logic [TAG_W-1:0] tag_reg;
   logic [WD_W-1:0]  wd_reg;
   logic             wd_hit;
   cmd_t             head;
   cmd_t             wr_cmd;
   logic             fifo_full, fifo_empty;
   logic             push, pop, launch, cap_ok, cap_to;

   logic [23:0]      central_reg;
   logic [11:0]      radius_reg;
   logic [1:0]       mode_reg;
   logic             res_valid_reg, res_err_reg;
   logic [7:0]       res_count_reg;
   logic [TAG_W-1:0] res_tag_reg;

   assign cmd_ready = !fifo_full;
   assign push      = cmd_valid && cmd_ready;
   assign wr_cmd    = '{central: cmd_central, radius: cmd_radius, mode: cmd_mode,
                        tag: CMD_TAG_W'(tag_reg)};

   set_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data (wr_cmd),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign wd_hit = (wd_reg == WD_W'(TIMEOUT - 1));

   always_comb begin
      state_next = state_reg;
      set_en     = 1'b0;
      launch     = 1'b0;
      pop        = 1'b0;
      cap_ok     = 1'b0;
      cap_to     = 1'b0;
      case (state_reg)
         IDLE: begin
            // Hold off while an unread result sits in the register.
            if (!fifo_empty && !set_busy && (!res_valid_reg || res_ready)) begin
               launch     = 1'b1;
               state_next = LAUNCH;
            end
         end
         LAUNCH: begin
            set_en     = 1'b1;
            state_next = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (wd_hit) begin
               cap_to     = 1'b1;
               pop        = 1'b1;
               state_next = DRAIN;
            end else if (set_busy) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (set_valid) begin
               cap_ok     = 1'b1;
               pop        = 1'b1;
               state_next = DRAIN;
            end else if (wd_hit) begin
               cap_to     = 1'b1;
               pop        = 1'b1;
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (!set_busy || wd_hit) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         tag_reg   <= '0;
         wd_reg    <= '0;
      end else begin
         state_reg <= state_next;
         if (push) tag_reg <= tag_reg + TAG_W'(1);
         // Watchdog restarts on launch and again on entering DRAIN.
         if (launch || (cap_ok || cap_to)) begin
            wd_reg <= '0;
         end else if (state_reg != IDLE) begin
            wd_reg <= wd_reg + WD_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         central_reg   <= '0;
         radius_reg    <= '0;
         mode_reg      <= '0;
         res_valid_reg <= 1'b0;
         res_count_reg <= '0;
         res_tag_reg   <= '0;
         res_err_reg   <= 1'b0;
      end else begin
         if (launch) begin
            central_reg <= head.central;
            radius_reg  <= head.radius;
            mode_reg    <= head.mode;
         end
         if (cap_ok || cap_to) begin
            res_valid_reg <= 1'b1;
            res_count_reg <= cap_ok ? set_candidate : 8'd0;
            res_tag_reg   <= TAG_W'(head.tag);
            res_err_reg   <= cap_to;
         end else if (res_ready) begin
            res_valid_reg <= 1'b0;
         end
      end
   end

   assign set_central = central_reg;
   assign set_radius  = radius_reg;
   assign set_mode    = mode_reg;
   assign res_valid   = res_valid_reg;
   assign res_count   = res_count_reg;
   assign res_tag     = res_tag_reg;
   assign res_err     = res_err_reg;

endmodule
